// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end. Issues in-order word requests to a
// variable-latency instruction memory and buffers the returned words,
// tagged with their PCs, in a small circular queue that feeds decode.
// A redirect from execute flushes the queue and arranges for every
// response still in flight to be discarded. Fetch stops once an ebreak
// has been enqueued, and resumes on the next redirect.
//
// Parameters:
//   DEPTH     queue entries; also the cap on queued + outstanding requests
//             (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req_*        request channel to instruction memory (valid/ready/addr)
//   imem_resp_*       in-order response channel from instruction memory
//   instr_valid/instr/instr_pc/instr_ready  queue head handshake to decode
//   redirect/redirect_pc  taken branch/jump from execute
//   halted            an ebreak has been enqueued; no further fetches
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] EBREAK  = 32'h0010_0073;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          resp_discard;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count_next;

  // Head of queue is presented straight from storage; no bypass from memory.
  assign instr_valid   = (count != '0);
  assign instr         = q_data[head];
  assign instr_pc      = q_pc[head];
  assign imem_req_addr = fetch_pc;

  // Request credit, response classification and counter next-state.
  always_comb begin
    credit_used    = {1'b0, count} + {1'b0, outstanding};
    // Credit covers both queued words and requests in flight, so every
    // accepted request is guaranteed a free slot when it returns.
    imem_req_valid = !rst && !halted && !redirect && (credit_used < DEPTH_W);
    req_fire       = imem_req_valid && imem_req_ready;
    // Stale responses (pre-redirect), responses racing a redirect, and
    // anything after an ebreak are dropped on the floor.
    resp_discard   = imem_resp_valid && ((drop != '0) || redirect || halted);
    push           = imem_resp_valid && !resp_discard;
    pop            = instr_valid && instr_ready && !redirect;

    if (req_fire && !imem_resp_valid) begin
      outstanding_next = outstanding + CW'(1);
    end else if (!req_fire && imem_resp_valid) begin
      outstanding_next = outstanding - CW'(1);
    end else begin
      outstanding_next = outstanding;
    end

    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end else begin
      count_next = count;
    end
  end

  // Control state: PCs, occupancy, in-flight bookkeeping and halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      head        <= '0;
      tail        <= '0;
      halted      <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      halted      <= 1'b0;
      outstanding <= outstanding_next;
      // Everything still in flight after this edge belongs to the old path.
      drop        <= outstanding_next;
    end else begin
      count       <= count_next;
      outstanding <= outstanding_next;
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        tail    <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      if (resp_discard && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if (push && (imem_resp_data == EBREAK)) begin
        halted <= 1'b1;
      end
    end
  end

  // Queue storage; contents are meaningless until covered by count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= imem_resp_data;
      q_pc[tail]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. An in-order variable-latency memory
// and a scoreboard of expected queue contents are kept here; responses to
// requests issued before the most recent redirect are recognised by an
// epoch tag on each request.
module tb_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  req_t        infl[$];
  ent_t        mq[$];
  logic [31:0] delivered[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          accepts = 0;
  logic [31:0] m_fetch = 32'h0;
  bit          m_halted = 1'b0;

  int          rdy_pct = 100;
  int          irdy_pct = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          redir_pct = 0;
  bit          force_redir = 1'b0;
  logic [31:0] redir_target = 32'h0;
  bit          ebreak8 = 1'b0;
  bit          rand_ebreak = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (ebreak8 && addr == 32'h8) return EBREAK;
    if (rand_ebreak && addr[6:2] == 5'd23) return EBREAK;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    infl.delete();
    mq.delete();
    delivered.delete();
    m_fetch = 32'h0;
    m_halted = 1'b0;
    epoch++;
    cyc = 0;
    rst = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    bit          r, rv, a, p, kept, exp_rv;
    logic [31:0] rpc, rdata;
    int          occ;
    r   = force_redir || (int'($urandom_range(0, 99)) < redir_pct);
    rpc = force_redir ? redir_target : (32'($urandom_range(0, 1023)) << 2);
    force_redir = 1'b0;
    rv    = (infl.size() != 0) && (infl[0].due <= cyc);
    rdata = rv ? mem_word(infl[0].addr) : 32'($urandom);
    redirect        = r;
    redirect_pc     = rpc;
    imem_resp_valid = rv;
    imem_resp_data  = rdata;
    imem_req_ready  = int'($urandom_range(0, 99)) < rdy_pct;
    instr_ready     = int'($urandom_range(0, 99)) < irdy_pct;
    #1;
    occ    = infl.size() + mq.size();
    exp_rv = !m_halted && !r && (occ < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, m_fetch);
    check("credit", 32'(imem_req_valid && (occ >= DEPTH)), 32'h0);
    check("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("instr_pc", instr_pc, mq[0].pc);
      check("instr", instr, mq[0].data);
    end
    check("halted", 32'(halted), 32'(m_halted));

    a    = exp_rv && imem_req_ready;
    p    = (mq.size() != 0) && instr_ready && !r;
    kept = rv && !r && !m_halted && (infl[0].epoch == epoch);
    if (r) begin
      mq.delete();
      epoch++;
      m_halted = 1'b0;
      m_fetch = rpc;
    end else begin
      if (p) begin
        delivered.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (kept) begin
        mq.push_back('{pc: infl[0].addr, data: rdata});
        if (rdata == EBREAK) m_halted = 1'b1;
      end
    end
    if (rv) void'(infl.pop_front());
    if (a) begin
      infl.push_back('{addr: m_fetch, epoch: epoch, due: cyc + int'($urandom_range(lat_lo, lat_hi))});
      m_fetch += 32'd4;
      accepts++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int first_valid;
    int n0;

    // Zero-stall stream with a single-cycle memory.
    do_reset();
    rdy_pct = 100; irdy_pct = 100; lat_lo = 1; lat_hi = 1; redir_pct = 0;
    first_valid = -1;
    for (int k = 0; k < 25; k++) begin
      if (instr_valid && first_valid < 0) first_valid = cyc;
      step();
    end
    check("zs_first_valid", 32'(first_valid), 32'd2);
    check("zs_count", 32'(delivered.size()), 32'd23);
    for (int i = 0; i < delivered.size(); i++) check("zs_pc", delivered[i], 32'(4 * i));

    // Backpressure fill, then release.
    do_reset();
    irdy_pct = 0;
    accepts = 0;
    repeat (10) step();
    check("bp_accepts", 32'(accepts), 32'd4);
    check("bp_req_idle", 32'(imem_req_valid), 32'h0);
    irdy_pct = 100;
    repeat (8) step();
    check("bp_delivered", 32'(delivered.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) if (i < delivered.size()) check("bp_pc", delivered[i], 32'(4 * i));

    // Redirect while two requests are in flight at latency 3.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (2) step();
    force_redir = 1'b1; redir_target = 32'h100;
    step();
    repeat (10) step();
    check("ri_delivered", 32'(delivered.size() > 0), 32'h1);
    if (delivered.size() > 0) check("ri_first_pc", delivered[0], 32'h100);

    // Redirect coincident with a response and a pop.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (5) step();
    n0 = delivered.size();
    force_redir = 1'b1; redir_target = 32'h200;
    step();
    check("co_empty", 32'(instr_valid), 32'h0);
    repeat (6) step();
    check("co_delivered", 32'(delivered.size() > n0), 32'h1);
    if (delivered.size() > n0) check("co_first_pc", delivered[n0], 32'h200);

    // Ebreak at PC 8 stops fetch; redirect resumes.
    do_reset();
    ebreak8 = 1'b1;
    repeat (15) step();
    check("eb_count", 32'(delivered.size()), 32'd3);
    for (int i = 0; i < 3; i++) if (i < delivered.size()) check("eb_pc", delivered[i], 32'(4 * i));
    check("eb_halted", 32'(halted), 32'h1);
    check("eb_req_idle", 32'(imem_req_valid), 32'h0);
    force_redir = 1'b1; redir_target = 32'h40;
    step();
    check("eb_unhalt", 32'(halted), 32'h0);
    repeat (6) step();
    check("eb_resume", 32'(delivered.size() > 3), 32'h1);
    if (delivered.size() > 3) check("eb_resume_pc", delivered[3], 32'h40);
    ebreak8 = 1'b0;

    // Random latency, readiness, redirects and ebreaks.
    do_reset();
    rand_ebreak = 1'b1;
    lat_lo = 1; lat_hi = 5; rdy_pct = 70; irdy_pct = 60; redir_pct = 2;
    repeat (2000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
